qpu_event_timing_queue: RTL

Timestamped event queue at the far end of the QIU write-back interface. Accepts committed quantum events (per-qubit event data, operand mask, absolute issue time) over a valid/ready handshake and buffers them in order. Runs the QPU timeline counter and releases each event to the analog/measurement front-end on the cycle its timestamp is reached. Flags events that arrive too late or out of time order.

---
 rtl/qpu_event_timing_queue_if.sv | 29 ++
 rtl/qpu_event_timing_queue.sv | 124 ++++++++++++
 2 files changed

// File: rtl/qpu_event_timing_queue_if.sv
// Write-back event channel into the QPU timing queue.
// The producer drives the event and its timestamp; the queue returns ready.
interface qpu_event_timing_queue_if #(
  parameter int unsigned EVENT_WIRE_WIDTH = 64,
  parameter int unsigned EVENT_NUM        = 9,
  parameter int unsigned TIME_WIDTH       = 32
);
  logic                        evt_i_valid;
  logic                        evt_i_ready;
  logic [EVENT_WIRE_WIDTH-1:0] evt_i_edata;
  logic [EVENT_NUM-1:0]        evt_i_oprand;
  logic [TIME_WIDTH-1:0]       evt_i_tdata;

  modport master (
    output evt_i_valid,
    output evt_i_edata,
    output evt_i_oprand,
    output evt_i_tdata,
    input  evt_i_ready
  );

  modport slave (
    input  evt_i_valid,
    input  evt_i_edata,
    input  evt_i_oprand,
    input  evt_i_tdata,
    output evt_i_ready
  );
endinterface

// File: rtl/qpu_event_timing_queue.sv
// Timestamped in-order event queue: buffers committed events and issues each one
// on the cycle the QPU timeline reaches its timestamp, flagging late and out-of-order events.
module qpu_event_timing_queue #(
  parameter int unsigned EVENT_WIRE_WIDTH = 64,
  parameter int unsigned EVENT_NUM        = 9,
  parameter int unsigned TIME_WIDTH       = 32,
  parameter int unsigned DEPTH            = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  qpu_event_timing_queue_if.slave     evt_if,
  input  logic                        tim_i_run,
  input  logic                        tim_i_clr,
  output logic                        evt_o_valid,
  output logic [EVENT_WIRE_WIDTH-1:0] evt_o_edata,
  output logic [EVENT_NUM-1:0]        evt_o_oprand,
  output logic                        evt_o_late,
  output logic [TIME_WIDTH-1:0]       tim_o_now,
  output logic [$clog2(DEPTH):0]      q_o_count,
  output logic                        err_o_order
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [EVENT_WIRE_WIDTH-1:0] r_mem_edata  [DEPTH];
  logic [EVENT_NUM-1:0]        r_mem_oprand [DEPTH];
  logic [TIME_WIDTH-1:0]       r_mem_tdata  [DEPTH];

  logic [AW:0]                 r_wptr;
  logic [AW:0]                 r_rptr;
  logic                        r_rdy_en;
  logic [TIME_WIDTH-1:0]       r_now;
  logic [TIME_WIDTH-1:0]       r_last_tdata;
  logic                        r_last_vld;
  logic                        r_err_order;
  logic                        r_out_valid;
  logic [EVENT_WIRE_WIDTH-1:0] r_out_edata;
  logic [EVENT_NUM-1:0]        r_out_oprand;
  logic                        r_out_late;

  logic                        w_full;
  logic                        w_empty;
  logic                        w_ready;
  logic                        w_push;
  logic [TIME_WIDTH-1:0]       w_diff;
  logic [TIME_WIDTH-1:0]       w_ord_diff;
  logic                        w_due;
  logic                        w_late;
  logic                        w_order_bad;

  always_comb begin
    w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_empty     = (r_wptr == r_rptr);
    // Ready comes only from registered state, never from a same-cycle pop.
    w_ready     = r_rdy_en && !w_full;
    w_push      = evt_if.evt_i_valid && w_ready;
    // Signed difference keeps the due test correct across timeline wrap.
    w_diff      = r_now - r_mem_tdata[r_rptr[AW-1:0]];
    w_due       = !w_empty && !w_diff[TIME_WIDTH-1];
    w_late      = w_due && (w_diff != '0);
    w_ord_diff  = evt_if.evt_i_tdata - r_last_tdata;
    w_order_bad = r_last_vld && w_ord_diff[TIME_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_edata[r_wptr[AW-1:0]]  <= evt_if.evt_i_edata;
      r_mem_oprand[r_wptr[AW-1:0]] <= evt_if.evt_i_oprand;
      r_mem_tdata[r_wptr[AW-1:0]]  <= evt_if.evt_i_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_rdy_en     <= 1'b0;
      r_now        <= '0;
      r_last_tdata <= '0;
      r_last_vld   <= 1'b0;
      r_err_order  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_edata  <= '0;
      r_out_oprand <= '0;
      r_out_late   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;

      if (tim_i_clr) begin
        r_now <= '0;
      end else if (tim_i_run) begin
        r_now <= r_now + 1'b1;
      end

      if (w_push) begin
        r_wptr       <= r_wptr + 1'b1;
        r_last_tdata <= evt_if.evt_i_tdata;
        r_last_vld   <= 1'b1;
        if (w_order_bad) begin
          r_err_order <= 1'b1;
        end
      end

      if (w_due) begin
        r_rptr <= r_rptr + 1'b1;
      end

      r_out_valid  <= w_due;
      r_out_edata  <= w_due ? r_mem_edata[r_rptr[AW-1:0]] : '0;
      r_out_oprand <= w_due ? r_mem_oprand[r_rptr[AW-1:0]] : '0;
      r_out_late   <= w_late;
    end
  end

  assign evt_if.evt_i_ready = w_ready;
  assign evt_o_valid        = r_out_valid;
  assign evt_o_edata        = r_out_edata;
  assign evt_o_oprand       = r_out_oprand;
  assign evt_o_late         = r_out_late;
  assign tim_o_now          = r_now;
  assign q_o_count          = r_wptr - r_rptr;
  assign err_o_order        = r_err_order;

endmodule
